weight_rd_responder: RTL
========================

Name: weight_rd_responder

Overview:
- Responder end of the encoder weight-read interface (mem_rd_en/mem_rd_addr -> mem_rd_data/mem_rd_valid) used by the QKV projection and other encoder stages.
- Holds a BUS_WIDTH-wide on-chip weight store, which the host loads through a write port under a load/commit protocol.
- Serves one read request per cycle with a fixed-latency pipelined response. There is no backpressure.

Parameters:
- BUS_WIDTH, 512, width of the read data word in bits; must be a multiple of 32.
- DEPTH_WORDS, 1024, number of BUS_WIDTH words in the store.
- BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.
- READ_LATENCY, 2, cycles from mem_rd_en to mem_rd_valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- mem_rd_en  in  1  read request strobe; one request per asserted cycle
- mem_rd_addr  in  32  byte address of the request
- mem_rd_data  out  BUS_WIDTH  response data
- mem_rd_valid  out  1  response strobe
- load_start  in  1  pulse; invalidates the store and enters loading
- load_commit  in  1  pulse; marks the store ready
- wr_en  in  1  weight word write strobe
- wr_addr  in  $clog2(DEPTH_WORDS)  word index to write
- wr_data  in  BUS_WIDTH  word to write
- ready  out  1  store is committed and serving
- rd_err  out  1  sticky error flag; cleared on load_start
- rd_count  out  32  count of successful reads since the last load_start

Behaviour:
- Reset values: mem_rd_valid=0, mem_rd_data=0, ready=0, rd_err=0, rd_count=0, state=S_EMPTY, response pipeline flushed. Store contents are not reset.
- States and transitions:
  - S_EMPTY: load_start -> S_LOADING.
  - S_LOADING: load_commit -> S_READY. load_start is ignored. If load_start and load_commit arrive in the same cycle, the commit wins.
  - S_READY: load_start -> S_LOADING and clears rd_err and rd_count. load_commit is ignored.
- ready=1 exactly while in S_READY, registered.
- Writes:
  - wr_en is honoured only in S_LOADING; it is ignored in all other states.
  - wr_addr >= DEPTH_WORDS is dropped and sets rd_err.
- Read decode, on the mem_rd_en cycle:
  - offset = mem_rd_addr - BASE_ADDR, taken modulo 2^32.
  - word = offset >> log2(BUS_WIDTH/8).
  - A request is good when: the state is S_READY, the low log2(BUS_WIDTH/8) bits of offset are 0, and word < DEPTH_WORDS. An address below BASE_ADDR wraps to a large offset and is therefore out of range.
- Read response:
  - Every request produces exactly one mem_rd_valid pulse, exactly READ_LATENCY cycles later. Back-to-back requests give back-to-back responses, in order.
  - A good request returns the stored word and increments rd_count. rd_count saturates at 32'hFFFF_FFFF.
  - A bad request returns all-zero data and sets rd_err. Bad requests are misaligned, out of range, or made while not ready.
  - When mem_rd_valid=0, mem_rd_data holds its last value.
- Same-cycle read and write to the same word: not possible, since reads are good only in S_READY and writes only in S_LOADING.
- load_start with responses in flight: responses already in flight complete with the data captured at their request cycle. New requests are bad from the next cycle.
- Reset mid-operation: in-flight responses are discarded and mem_rd_valid is 0 immediately (asynchronous).

Optional Feature:
- Macro: WEIGHT_RD_PARITY_EN.
- Defined:
  - Adds output port mem_rd_parity [BUS_WIDTH/32-1:0]. Bit i is the even parity (XOR) of mem_rd_data[32*i+31:32*i].
  - It is aligned with mem_rd_valid and is 0 on reset and on bad responses.
- Undefined: the port is absent and no parity logic is built.

Test Plan:
- Reset, then mem_rd_en with addr 0x0 -> mem_rd_valid at cycle +2, data=0, rd_err=1, ready=0.
- load_start; write word 5 = {16{32'hA5A5_0005}}; load_commit; read addr 0x140 -> at +2 valid=1, data={16{32'hA5A5_0005}}, rd_count=1, rd_err=0.
- 8 consecutive reads of 0x0, 0x40, ... 0x1C0 after loading word i = i -> 8 consecutive valid pulses starting at +2, data 0..7 in order, rd_count=8.
- Read 0x44 (misaligned) and then 0x10000 (word 1024) -> both responses are zero, rd_err=1, rd_count unchanged.
- Issue a read of 0x40, then load_start the next cycle -> the read still returns word 1. A read issued the cycle after load_start returns zero; ready=0 and rd_count=0.
- With WEIGHT_RD_PARITY_EN defined, read word 0 = {16{32'h0000_0001}} -> mem_rd_parity=16'hFFFF.

Source files
------------

// File: rtl/weight_rd_responder.sv
// weight_rd_responder: on-chip weight store answering encoder read requests with fixed latency.
//
// Optional feature: define WEIGHT_RD_PARITY_EN to add per-32-bit-lane even parity on read data.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_rd_en, mem_rd_addr      read request strobe and byte address (one request per cycle)
//   mem_rd_data, mem_rd_valid   response word and strobe, READ_LATENCY cycles after request
//   load_start, load_commit     host pulses: invalidate-and-load / mark store ready
//   wr_en, wr_addr, wr_data     weight word write port, honoured only while loading
//   ready                       store committed and serving
//   rd_err                      sticky error (bad read or bad write), cleared on load_start
//   rd_count                    saturating count of good reads since last load_start
//   mem_rd_parity               (WEIGHT_RD_PARITY_EN) even parity per 32-bit lane of mem_rd_data
module weight_rd_responder #(
    parameter int          BUS_WIDTH    = 512,
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_rd_en,
    input  logic [31:0]                    mem_rd_addr,
    output logic [BUS_WIDTH-1:0]           mem_rd_data,
    output logic                           mem_rd_valid,
    input  logic                           load_start,
    input  logic                           load_commit,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]           wr_data,
`ifdef WEIGHT_RD_PARITY_EN
    output logic [BUS_WIDTH/32-1:0]        mem_rd_parity,
`endif
    output logic                           ready,
    output logic                           rd_err,
    output logic [31:0]                    rd_count
);
    localparam int LSB = $clog2(BUS_WIDTH / 8);
    localparam int AW  = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_READY} state_t;

    state_t                                    r_state;
    logic                                      r_ready;
    logic                                      r_err;
    logic [31:0]                               r_cnt;
    logic [BUS_WIDTH-1:0]                      r_mem [DEPTH_WORDS];
    logic [READ_LATENCY-1:0]                   r_pv;
    logic [READ_LATENCY-1:0][BUS_WIDTH-1:0]    r_pd;

    logic [31:0]          w_off;
    logic                 w_good;
    logic                 w_start;
    logic                 w_wr_ok;
    logic                 w_wr_bad;
    logic [BUS_WIDTH-1:0] w_rdata;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_off    = mem_rd_addr - BASE_ADDR;
    assign w_good   = r_state == S_READY && w_off[LSB-1:0] == '0 && (w_off >> LSB) < 32'(DEPTH_WORDS);
    assign w_rdata  = w_good ? r_mem[w_off[LSB +: AW]] : '0;
    assign w_start  = load_start && r_state != S_LOADING;
    assign w_wr_ok  = r_state == S_LOADING && wr_en && 32'(wr_addr) < 32'(DEPTH_WORDS);
    assign w_wr_bad = r_state == S_LOADING && wr_en && 32'(wr_addr) >= 32'(DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_EMPTY: if (load_start) r_state <= S_LOADING;
                // Commit wins over a simultaneous load_start, which is ignored here anyway.
                S_LOADING: if (load_commit) begin
                    r_state <= S_READY;
                    r_ready <= 1'b1;
                end
                S_READY: if (load_start) begin
                    r_state <= S_LOADING;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_ready <= 1'b0;
                end
            endcase
            if (w_start) r_err <= 1'b0;
            else if ((mem_rd_en && !w_good) || w_wr_bad) r_err <= 1'b1;
            if (w_start) r_cnt <= '0;
            else if (mem_rd_en && w_good && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
        end
    end

    // Data is captured at the request cycle and each stage only loads when a
    // response moves into it, so the output word holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            r_pd <= '0;
        end else begin
            r_pv[0] <= mem_rd_en;
            if (mem_rd_en) r_pd[0] <= w_rdata;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign mem_rd_valid = r_pv[READ_LATENCY-1];
    assign mem_rd_data  = r_pd[READ_LATENCY-1];
    assign ready        = r_ready;
    assign rd_err       = r_err;
    assign rd_count     = r_cnt;

`ifdef WEIGHT_RD_PARITY_EN
    // Bad responses and reset carry zero data, so their parity is zero too.
    for (genvar g = 0; g < BUS_WIDTH / 32; g++) begin : g_par
        assign mem_rd_parity[g] = ^mem_rd_data[32*g +: 32];
    end
`endif
endmodule
